// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and pointer-width helper for the UART receive buffer
//
// Contents:
//   UART_DATA_WIDTH  default width of one received byte
//   rx_fifo_state_t  presentation FSM states {IDLE, PRESENT, WAIT_ACK}
//   addr_width()     pointer width for a FIFO of a given depth
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_ACK = 2'd2
  } rx_fifo_state_t;

  // A depth of 1 would give a zero-width pointer; clamp to 1 bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count, full and empty flags
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (pointers and count)
//   i_push       write i_push_data this cycle; caller guarantees not full unless popping
//   i_push_data  byte to store
//   i_pop        remove the head this cycle; caller guarantees not empty
//   o_pop_data   current head of the FIFO (valid while not empty)
//   o_full       count equals DEPTH
//   o_empty      count equals zero
//   o_count      number of stored entries, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_push_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_pop_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [addr_width(DEPTH):0]    o_count
);

  localparam int ADDR_W = addr_width(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;

  // Storage has no reset: contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (i_pop && !i_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = (r_count == (ADDR_W + 1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer presenting bytes to the CPU one at a time with interrupt/ack handshake
//
// Optional build macro: UART_RX_FIFO_LEVEL_INT_EN
//   defined   - cpu_int is a level, high from the presentation until the ack edge
//   undefined - cpu_int is a single-cycle pulse per presented byte
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   uart_byte       received byte, valid with uart_strobe
//   uart_strobe     one-cycle "byte received" pulse
//   cpu_data        byte currently presented to the CPU
//   cpu_int         interrupt to the CPU
//   cpu_end_read    CPU acknowledge; only its rising edge matters
//   fifo_count      bytes stored, not counting the presented byte
//   overflow        sticky: a byte was dropped because the FIFO was full
//   clear_overflow  synchronous clear of overflow
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] uart_byte,
  input  logic                  uart_strobe,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_int,
  input  logic                  cpu_end_read,
  output logic [ADDR_W:0]       fifo_count,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  rx_fifo_state_t r_state;
  rx_fifo_state_t w_next_state;

  logic [DATA_WIDTH-1:0] r_cpu_data;
  logic                  r_cpu_int;
  logic                  r_overflow;
  logic                  r_cpu_end_read_q;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_ack_rise;
  logic                  w_int_next;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic [ADDR_W:0]       w_count;

  assign w_ack_rise = cpu_end_read & ~r_cpu_end_read_q;

  // A full FIFO still accepts a byte when the FSM frees a slot in the same cycle.
  assign w_push = uart_strobe & (~w_fifo_full | w_pop);
  assign w_drop = uart_strobe & w_fifo_full & ~w_pop;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (uart_byte),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = PRESENT;
        end
      end
      PRESENT: begin
        w_next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (w_ack_rise) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // cpu_int is registered, so it rises on the edge that ends PRESENT.
`ifdef UART_RX_FIFO_LEVEL_INT_EN
  assign w_int_next = (r_state == PRESENT) |
                      (r_cpu_int & ~((r_state == WAIT_ACK) & w_ack_rise));
`else
  assign w_int_next = (r_state == PRESENT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_data       <= '0;
      r_cpu_int        <= 1'b0;
      r_overflow       <= 1'b0;
      r_cpu_end_read_q <= 1'b0;
    end else begin
      r_cpu_end_read_q <= cpu_end_read;
      r_cpu_int        <= w_int_next;
      if (w_pop) begin
        r_cpu_data <= w_head;
      end
      // A drop beats a simultaneous clear so no loss goes unreported.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign cpu_data   = r_cpu_data;
  assign cpu_int    = r_cpu_int;
  assign fifo_count = w_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] uart_byte = '0;
  logic          uart_strobe = 1'b0;
  logic [DW-1:0] cpu_data;
  logic          cpu_int;
  logic          cpu_end_read = 1'b0;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          clear_overflow = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a byte queue plus the presented byte and when it was loaded.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data = '0;
  bit            m_busy = 1'b0;
  bit            m_ov = 1'b0;
  bit            m_prev_end = 1'b0;
  int            m_cyc = 0;
  int            m_load_cyc = 0;

  int            int_rises = 0;
  bit            last_int = 1'b0;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_byte      (uart_byte),
    .uart_strobe    (uart_strobe),
    .cpu_data       (cpu_data),
    .cpu_int        (cpu_int),
    .cpu_end_read   (cpu_end_read),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every clock edge, reset asynchronously.
  initial begin
    bit ack_rise;
    bit full;
    bit pop;
    bit drop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_data     = '0;
        m_busy     = 1'b0;
        m_ov       = 1'b0;
        m_prev_end = 1'b0;
        m_load_cyc = 0;
      end else begin
        m_cyc++;
        ack_rise   = cpu_end_read && !m_prev_end;
        m_prev_end = cpu_end_read;
        full       = (m_q.size() == DEPTH);
        pop        = !m_busy && (m_q.size() != 0);
        drop       = uart_strobe && full && !pop;
        if (pop) begin
          m_data     = m_q.pop_front();
          m_busy     = 1'b1;
          m_load_cyc = m_cyc;
        end else if (m_busy && ack_rise && (m_cyc >= m_load_cyc + 2)) begin
          // The ack only counts once the interrupt phase is over.
          m_busy = 1'b0;
        end
        if (uart_strobe && !drop) begin
          m_q.push_back(uart_byte);
        end
        if (drop) begin
          m_ov = 1'b1;
        end else if (clear_overflow) begin
          m_ov = 1'b0;
        end
      end
    end
  end

  // Every falling edge: compare all outputs against the model.
  initial begin
    bit exp_int;
    forever begin
      @(negedge clk);
`ifdef UART_RX_FIFO_LEVEL_INT_EN
      exp_int = m_busy && (m_cyc >= m_load_cyc + 1);
`else
      exp_int = m_busy && (m_cyc == m_load_cyc + 1);
`endif
      check("cpu_data",   32'(cpu_data),   32'(m_data));
      check("cpu_int",    32'(cpu_int),    32'(exp_int));
      check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      check("overflow",   32'(overflow),   32'(m_ov));
      if (cpu_int && !last_int) int_rises++;
      last_int = cpu_int;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [DW-1:0] b);
    uart_byte   = b;
    uart_strobe = 1'b1;
    tick(1);
    uart_strobe = 1'b0;
  endtask

  task automatic ack_pulse();
    cpu_end_read = 1'b1;
    tick(1);
    cpu_end_read = 1'b0;
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r0;
    tick(3);
    check("reset_cpu_data", 32'(cpu_data), 32'h0);
    check("reset_count",    32'(fifo_count), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Single byte: presented, one interrupt pulse, FIFO empty again.
    r0 = int_rises;
    strobe(8'hA5);
    tick(3);
    check("a5_data",  32'(cpu_data), 32'hA5);
    check("a5_int",   32'(int_rises - r0), 32'd1);
    check("a5_count", 32'(fifo_count), 32'd0);
    ack_pulse();

    // Three spaced bytes, acked one at a time in order.
    strobe(8'h11); tick(1);
    strobe(8'h22); tick(1);
    strobe(8'h33); tick(4);
    check("seq_data0",  32'(cpu_data), 32'h11);
    check("seq_count0", 32'(fifo_count), 32'd2);
    ack_pulse();
    check("seq_data1",  32'(cpu_data), 32'h22);
    check("seq_count1", 32'(fifo_count), 32'd1);
    ack_pulse();
    check("seq_data2",  32'(cpu_data), 32'h33);
    check("seq_count2", 32'(fifo_count), 32'd0);
    ack_pulse();

    // Ten back-to-back bytes: one presented, eight stored, last one dropped.
    for (int i = 0; i < 10; i++) strobe(8'(i));
    tick(2);
    check("ovf_data",  32'(cpu_data), 32'h00);
    check("ovf_count", 32'(fifo_count), 32'd8);
    check("ovf_flag",  32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full FIFO: strobe lands on the cycle the FSM pops, so it is accepted.
    cpu_end_read = 1'b1;
    tick(1);
    uart_byte   = 8'h5A;
    uart_strobe = 1'b1;
    tick(1);
    uart_strobe  = 1'b0;
    cpu_end_read = 1'b0;
    tick(3);
    check("full_pop_data",  32'(cpu_data), 32'h01);
    check("full_pop_count", 32'(fifo_count), 32'd8);
    check("full_pop_ovf",   32'(overflow), 32'd0);

    // Ack held high: only one advance until it drops and rises again.
    cpu_end_read = 1'b1;
    tick(20);
    check("held_data",  32'(cpu_data), 32'h02);
    check("held_count", 32'(fifo_count), 32'd7);
    cpu_end_read = 1'b0;
    tick(1);
    ack_pulse();
    check("rearm_data",  32'(cpu_data), 32'h03);
    check("rearm_count", 32'(fifo_count), 32'd6);
    ack_pulse();
    check("pre_rst_count", 32'(fifo_count), 32'd5);

    // Asynchronous reset mid-stream discards everything at once.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_data",  32'(cpu_data), 32'h0);
    check("async_rst_int",   32'(cpu_int), 32'h0);
    check("async_rst_count", 32'(fifo_count), 32'h0);
    check("async_rst_ovf",   32'(overflow), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    strobe(8'h77);
    tick(3);
    check("post_rst_data",  32'(cpu_data), 32'h77);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    ack_pulse();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
